// File: rtl/store_pkg.sv
// Shared types and defaults for the store narrowing path.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        FIN  = 2'b10,
        ERR  = 2'b11
    } state_t;

    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/store_lane_align.sv
// Maps a store size, low address bits and register value onto byte lanes.
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] data,
    output logic        fits,
    output logic        illegal
);

    size_t sz;
    assign sz = size_t'(size);

    // Lane replication, byte enables, round-trip check and alignment error.
    always_comb begin
        be      = '0;
        data    = '0;
        fits    = 1'b0;
        illegal = 1'b0;
        case (sz)
            SZ_BYTE: begin
                be   = 4'b0001 << addr_lo;
                data = {4{wdata[7:0]}};
                fits = (&wdata[31:7]) | ~(|wdata[31:7]);
            end
            SZ_HALF: begin
                illegal = addr_lo[0];
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                data    = {2{wdata[15:0]}};
                fits    = (&wdata[31:15]) | ~(|wdata[31:15]);
            end
            SZ_WORD: begin
                illegal = |addr_lo;
                be      = 4'b1111;
                data    = wdata;
                fits    = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow.sv
// Store path: narrows a register value onto byte lanes and runs one
// watchdog-guarded write transaction to data memory.
//
//   state | meaning
//   IDLE  | waiting for start; inputs latched on acceptance
//   REQ   | mem_req held, watchdog counting, waiting for mem_ack
//   FIN   | done pulse (success or watchdog abort)
//   ERR   | done pulse with err_align, no memory access made
module store_narrow
    import store_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err_align,
    output logic        err_timeout,
    output logic        fits,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack
);

    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t         state, state_nxt;
    logic [WDW-1:0] wd;
    logic           fits_q;
    logic           accept;
    logic           expire;
    logic [3:0]     la_be;
    logic [31:0]    la_data;
    logic           la_fits;
    logic           la_illegal;

    store_lane_align u_align (
        .size    (size),
        .addr_lo (addr[1:0]),
        .wdata   (wdata),
        .be      (la_be),
        .data    (la_data),
        .fits    (la_fits),
        .illegal (la_illegal)
    );

    // Next-state decode; ack takes priority over watchdog expiry.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = la_illegal ? ERR : REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_nxt = FIN;
                end else if (wd == WDW'(TIMEOUT - 1)) begin
                    expire    = 1'b1;
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Watchdog: zero outside REQ, so it starts from zero on every request.
    always_ff @(posedge clk) begin
        if (reset)             wd <= '0;
        else if (state == REQ) wd <= wd + WDW'(1);
        else                   wd <= '0;
    end

    // Registered outputs derived from the upcoming state; memory-side
    // values are captured once at acceptance and held thereafter.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            err_align   <= 1'b0;
            err_timeout <= 1'b0;
            fits        <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            fits_q      <= 1'b0;
        end else begin
            busy        <= (state_nxt != IDLE);
            done        <= (state_nxt == FIN) || (state_nxt == ERR);
            err_align   <= (state_nxt == ERR);
            err_timeout <= expire;
            fits        <= (state_nxt == FIN) ? fits_q : 1'b0;
            mem_req     <= (state_nxt == REQ);
            if (accept && !la_illegal) begin
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wdata <= la_data;
                mem_be    <= la_be;
                fits_q    <= la_fits;
            end
        end
    end

endmodule

// File: tb/tb_store_narrow.sv
// Scoreboard bench for store_narrow: expectations queued at start,
// compared when done pulses and while mem_req is held.
module tb_store_narrow;

    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err_align;
    logic        err_timeout;
    logic        fits;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        fits;
        logic        ealign;
        logic        etime;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 0;

    store_narrow #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .size        (size),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .err_align   (err_align),
        .err_timeout (err_timeout),
        .fits        (fits),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ack     (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: lanes by modulo of the access width, fits by a real
    // narrow-then-sign-extend round trip.
    function automatic exp_t model(input logic [1:0] sz, input logic [31:0] a,
                                   input logic [31:0] d, input int ack_dly);
        exp_t        e;
        int          nb;
        int          off;
        logic [31:0] sx;
        nb       = 1 << sz;
        off      = int'(a[1:0]);
        e.ealign = (sz == 2'b11) || ((off % nb) != 0);
        e.addr   = a & 32'hFFFF_FFFC;
        e.be     = '0;
        e.data   = '0;
        for (int i = 0; i < 4; i++) begin
            e.be[i]          = (i >= off) && (i < off + nb);
            e.data[8*i +: 8] = d[8*(i % nb) +: 8];
        end
        case (sz)
            2'b00:   sx = {{24{d[7]}}, d[7:0]};
            2'b01:   sx = {{16{d[15]}}, d[15:0]};
            default: sx = d;
        endcase
        e.fits  = !e.ealign && (sx == d);
        e.etime = !e.ealign && !(ack_dly >= 0 && ack_dly < TO);
        return e;
    endfunction

    // Monitor: done pops the scoreboard; held request must match it.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                chk("done_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    chk("err_align", err_align, mon_e.ealign);
                    chk("err_timeout", err_timeout, mon_e.etime);
                    chk("fits", fits, mon_e.fits);
                end
            end else begin
                chk("flags_idle", {29'b0, err_align, err_timeout, fits}, 0);
            end
            if (mem_req) begin
                chk("busy_req", busy, 1);
                if (q.size() != 0) begin
                    chk("mem_addr", mem_addr, q[0].addr);
                    chk("mem_be", mem_be, q[0].be);
                    chk("mem_wdata", mem_wdata, q[0].data);
                end
            end
        end
    end

    // One transaction. ack_dly = REQ cycles before the acked one (-1: never).
    // b2b leaves an ignored start up in the done cycle so the next call
    // starts in the first IDLE cycle.
    task automatic txn(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       input int ack_dly, input bit poke, input bit b2b);
        exp_t e;
        int   cyc;
        int   nreq;
        int   exp_req;
        bit   seen;
        e       = model(sz, a, d, ack_dly);
        exp_req = e.ealign ? 0 : ((ack_dly >= 0 && ack_dly < TO) ? ack_dly + 1 : TO);
        @(negedge clk);
        q.push_back(e);
        start = 1'b1; size = sz; addr = a; wdata = d;
        @(negedge clk);
        start = 1'b0; size = 2'($urandom); addr = $urandom; wdata = $urandom;
        cyc = 1; nreq = 0; seen = 0;
        while (cyc < 80 && !seen) begin
            if (done) begin
                seen = 1;
            end else begin
                if (mem_req) begin
                    nreq++;
                    mem_ack = (nreq - 1 == ack_dly);
                end else begin
                    mem_ack = 1'b0;
                end
                start = poke && (cyc == 3);
                @(negedge clk);
                cyc++;
            end
        end
        mem_ack = 1'b0;
        start   = 1'b0;
        chk("done_seen", 32'(seen), 1);
        chk("req_cycles", nreq, exp_req);
        chk("done_latency", cyc, exp_req + 1);
        chk("busy_at_done", busy, 1);
        if (b2b) begin
            start = 1'b1; size = 2'b11; addr = $urandom; wdata = $urandom;
        end else begin
            @(negedge clk);
            chk("idle_after", busy, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1; start = 1'b0; size = '0; addr = '0; wdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {29'b0, err_align, err_timeout, fits}, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", mem_be, 0);
        reset  = 1'b0;
        mon_en = 1;

        // ack outside REQ is ignored
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); chk("ack_idle_busy", busy, 0); mem_ack = 1'b0;
        @(negedge clk); chk("ack_idle_req", mem_req, 0);

        txn(2'b00, 32'h0000_1003, 32'hFFFF_FF80, 0, 0, 0);
        txn(2'b01, 32'h0000_2002, 32'h0001_8000, 0, 0, 0);
        txn(2'b01, 32'h0000_2001, 32'h0000_1234, 0, 0, 0);
        txn(2'b10, 32'h0000_0040, 32'h1234_5678, 5, 1, 0);
        txn(2'b10, 32'h0000_0100, 32'hDEAD_BEEF, -1, 0, 0);
        txn(2'b10, 32'h0000_0104, 32'hCAFE_F00D, TO - 1, 0, 0);
        txn(2'b11, 32'h0000_0200, 32'h0000_0001, 0, 0, 0);

        // back-to-back: each new start lands in the first IDLE cycle
        txn(2'b00, 32'h0000_0005, 32'h0000_007F, 0, 0, 1);
        txn(2'b01, 32'h0000_0006, 32'hFFFF_8001, 1, 0, 1);
        txn(2'b10, 32'h0000_0042, 32'h0000_0000, 0, 0, 1);
        txn(2'b00, 32'h0000_0000, 32'h0000_0100, 2, 0, 0);

        // reset in the second REQ cycle
        @(negedge clk);
        start = 1'b1; size = 2'b10; addr = 32'h0000_0080; wdata = 32'hA5A5_A5A5;
        @(negedge clk); start = 1'b0;
        chk("mid_req1", mem_req, 1);
        @(negedge clk);
        chk("mid_req2", mem_req, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_be", mem_be, 0);
        repeat (4) begin
            @(negedge clk);
            chk("mid_rst_no_done", done, 0);
        end

        for (int i = 0; i < 12; i++) begin
            txn(2'($urandom), $urandom, $urandom, $urandom_range(0, TO), 0,
                (i % 3 == 0) && (i < 11));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
